// File: rtl/myfilter_pkg.sv
// -----------------------------------------------------------------------------
// myfilter_pkg
// Shared constants and types for the filter's I2C configuration port.
//   I2C_ADDRESS_DEFAULT     : default 7-bit slave address (7'h3A)
//   I2C_FRAME_BYTES_DEFAULT : default data bytes per frame (4)
//   I2C_BITS_PER_BYTE       : bit count that marks a complete byte (8)
//   i2c_frame_state_t       : frame controller states
//   addr_hit()              : address/RW decode for the 8-bit address byte
// -----------------------------------------------------------------------------
package myfilter_pkg;

    localparam logic [6:0]  I2C_ADDRESS_DEFAULT     = 7'h3A;
    localparam int unsigned I2C_FRAME_BYTES_DEFAULT = 4;
    localparam logic [3:0]  I2C_BITS_PER_BYTE       = 4'd8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
        DATA      = 2'd2,
        WAIT_STOP = 2'd3
    } i2c_frame_state_t;

    // An address byte is accepted when R/W is write (0) and the upper seven
    // bits name this slave, or name the general-call address when enabled.
    function automatic logic addr_hit(
        input logic [7:0] rx,
        input logic [6:0] own_addr,
        input logic       gencall_en
    );
        logic own_s;
        logic gc_s;
        own_s = (rx[7:1] == own_addr);
        gc_s  = gencall_en && (rx[7:1] == 7'h00);
        return (rx[0] == 1'b0) && (own_s || gc_s);
    endfunction

endpackage

// File: rtl/i2c_frame_ctrl_sva.sv
// -----------------------------------------------------------------------------
// i2c_frame_ctrl_sva
// Assertion checker for i2c_frame_ctrl, attached from outside the design.
// Ports:
//   clk, rst_n : clock / async active-low reset of the checked block
//   state      : frame controller state register
//   bitcnt     : bit counter register
//   byteok     : byte-complete status
//   frameok    : frame-complete status
// -----------------------------------------------------------------------------
module i2c_frame_ctrl_sva
    import myfilter_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    input i2c_frame_state_t state,
    input logic [3:0]       bitcnt,
    input logic             byteok,
    input logic             frameok
);

    a_byteok_in_data : assert property (@(posedge clk) disable iff (!rst_n)
        byteok |-> (state == DATA));

    a_frameok_ctx : assert property (@(posedge clk) disable iff (!rst_n)
        frameok |-> (byteok || (state == WAIT_STOP)));

    a_bitcnt_range : assert property (@(posedge clk) disable iff (!rst_n)
        bitcnt <= I2C_BITS_PER_BYTE);

endmodule

// File: rtl/i2c_frame_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_frame_ctrl
// Frame-level controller for the I2C slave configuration port. Samples SDA on
// SCL rising edges, counts bits and bytes, checks the slave address and
// reports byte/frame completion to i2c_fsm, which answers with next/clr.
//
// Optional feature macro: I2C_FRAME_CTRL_GENCALL_EN
//   defined   : general-call address 7'h00 (write) is also accepted
//   undefined : only I2C_ADDRESS is accepted
//
// Parameters:
//   I2C_ADDRESS : 7-bit slave address matched by this block
//   FRAME_BYTES : data bytes per complete frame (1..15)
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   start_in     : START / repeated START pulse
//   stop_in      : STOP pulse
//   scl_rise_in  : synchronized SCL rising-edge pulse
//   sda_in       : synchronized SDA level
//   next_in      : byte consumed, advance
//   clr_in       : abort frame, return to IDLE
//   addrok_out   : address matched with write direction
//   byteok_out   : data byte complete on rxbyte_out
//   frameok_out  : all FRAME_BYTES data bytes received
//   lastbit_out  : next SCL rise carries bit 0 (combinational from registers)
//   rxbyte_out   : receive shift register, MSB first
//   byteidx_out  : 0-based index of current data byte
// -----------------------------------------------------------------------------
module i2c_frame_ctrl
    import myfilter_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDRESS = I2C_ADDRESS_DEFAULT,
    parameter int unsigned FRAME_BYTES = I2C_FRAME_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_in,
    input  logic       stop_in,
    input  logic       scl_rise_in,
    input  logic       sda_in,
    input  logic       next_in,
    input  logic       clr_in,
    output logic       addrok_out,
    output logic       byteok_out,
    output logic       frameok_out,
    output logic       lastbit_out,
    output logic [7:0] rxbyte_out,
    output logic [3:0] byteidx_out
);

`ifdef I2C_FRAME_CTRL_GENCALL_EN
    localparam logic GENCALL_EN = 1'b1;
`else
    localparam logic GENCALL_EN = 1'b0;
`endif

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);
    localparam logic [3:0] LAST_BIT = I2C_BITS_PER_BYTE - 4'd1;

    i2c_frame_state_t state_r, state_s;
    logic [3:0]       bitcnt_r, bitcnt_s;
    logic [3:0]       byteidx_r, byteidx_s;
    logic [7:0]       rxbyte_r, rxbyte_s;
    logic             addrok_r, addrok_s;
    logic             byteok_r, byteok_s;
    logic             frameok_r, frameok_s;

    logic             active_s;
    logic             byte_done_s;
    logic [7:0]       shifted_s;

    // Shared decodes: receiving states, full byte held, next shift value.
    always_comb begin
        active_s    = (state_r == ADDR) || (state_r == DATA);
        byte_done_s = (bitcnt_r == I2C_BITS_PER_BYTE);
        shifted_s   = {rxbyte_r[6:0], sda_in};
    end

    // Next-state logic; events are taken in priority start > stop > clr > next > scl.
    always_comb begin
        state_s   = state_r;
        bitcnt_s  = bitcnt_r;
        byteidx_s = byteidx_r;
        rxbyte_s  = rxbyte_r;
        addrok_s  = addrok_r;
        byteok_s  = byteok_r;
        frameok_s = frameok_r;

        if (start_in) begin
            state_s   = ADDR;
            bitcnt_s  = 4'd0;
            byteidx_s = 4'd0;
            addrok_s  = 1'b0;
            byteok_s  = 1'b0;
            frameok_s = 1'b0;
        end else if (stop_in || clr_in) begin
            state_s   = IDLE;
            bitcnt_s  = 4'd0;
            byteidx_s = 4'd0;
            addrok_s  = 1'b0;
            byteok_s  = 1'b0;
            frameok_s = 1'b0;
        end else if (next_in && byte_done_s) begin
            // next only means something once a full byte (plus ACK slot) is held
            case (state_r)
                ADDR: begin
                    if (addrok_r) begin
                        state_s   = DATA;
                        addrok_s  = 1'b0;
                        bitcnt_s  = 4'd0;
                        byteidx_s = 4'd0;
                    end else begin
                        state_s = state_r;
                    end
                end
                DATA: begin
                    byteok_s = 1'b0;
                    bitcnt_s = 4'd0;
                    if (frameok_r) begin
                        state_s = WAIT_STOP;
                    end else begin
                        byteidx_s = byteidx_r + 4'd1;
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end else if (scl_rise_in && active_s && !byte_done_s) begin
            rxbyte_s = shifted_s;
            bitcnt_s = bitcnt_r + 4'd1;
            if (bitcnt_r == LAST_BIT) begin
                // this rise completes the byte: judge it on the shifted value
                case (state_r)
                    ADDR: begin
                        if (addr_hit(shifted_s, I2C_ADDRESS, GENCALL_EN)) begin
                            addrok_s = 1'b1;
                        end else begin
                            state_s = WAIT_STOP;
                        end
                    end
                    DATA: begin
                        byteok_s = 1'b1;
                        if (byteidx_r == LAST_IDX) begin
                            frameok_s = 1'b1;
                        end else begin
                            frameok_s = frameok_r;
                        end
                    end
                    default: begin
                        state_s = state_r;
                    end
                endcase
            end else begin
                state_s = state_r;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, counters, shift register and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bitcnt_r  <= 4'd0;
            byteidx_r <= 4'd0;
            rxbyte_r  <= 8'h00;
            addrok_r  <= 1'b0;
            byteok_r  <= 1'b0;
            frameok_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            bitcnt_r  <= bitcnt_s;
            byteidx_r <= byteidx_s;
            rxbyte_r  <= rxbyte_s;
            addrok_r  <= addrok_s;
            byteok_r  <= byteok_s;
            frameok_r <= frameok_s;
        end
    end

    assign addrok_out  = addrok_r;
    assign byteok_out  = byteok_r;
    assign frameok_out = frameok_r;
    assign rxbyte_out  = rxbyte_r;
    assign byteidx_out = byteidx_r;
    // Decoded from registers so i2c_fsm sees it before the final rise.
    assign lastbit_out = active_s && (bitcnt_r == LAST_BIT);

endmodule

// File: tb/tb_i2c_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_frame_ctrl
// Directed bench for i2c_frame_ctrl with a behavioural frame model.
// Honours I2C_FRAME_CTRL_GENCALL_EN for the general-call expectation.
// -----------------------------------------------------------------------------
module tb_i2c_frame_ctrl;
    import myfilter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_in = 1'b0;
    logic       stop_in = 1'b0;
    logic       scl_rise_in = 1'b0;
    logic       sda_in = 1'b0;
    logic       next_in = 1'b0;
    logic       clr_in = 1'b0;
    logic       addrok_out;
    logic       byteok_out;
    logic       frameok_out;
    logic       lastbit_out;
    logic [7:0] rxbyte_out;
    logic [3:0] byteidx_out;

    always #5 clk = ~clk;

    i2c_frame_ctrl #(.I2C_ADDRESS(7'h3A), .FRAME_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .stop_in(stop_in),
        .scl_rise_in(scl_rise_in), .sda_in(sda_in), .next_in(next_in),
        .clr_in(clr_in), .addrok_out(addrok_out), .byteok_out(byteok_out),
        .frameok_out(frameok_out), .lastbit_out(lastbit_out),
        .rxbyte_out(rxbyte_out), .byteidx_out(byteidx_out)
    );

    i2c_frame_ctrl_sva u_sva (
        .clk(clk), .rst_n(rst_n), .state(dut.state_r), .bitcnt(dut.bitcnt_r),
        .byteok(byteok_out), .frameok(frameok_out)
    );

`ifdef I2C_FRAME_CTRL_GENCALL_EN
    localparam int GC = 1;
`else
    localparam int GC = 0;
`endif
    localparam int OWN = 58;   // 7'h3A
    localparam int FB  = 4;

    // model phases
    localparam int P_IDLE = 0, P_ADDR = 1, P_DATA = 2, P_WAIT = 3;

    int m_ph, m_cnt, m_idx, m_sh, m_a, m_b, m_f;
    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        m_ph = P_IDLE; m_cnt = 0; m_idx = 0; m_sh = 0;
        m_a = 0; m_b = 0; m_f = 0;
    endtask

    // One clock of protocol behaviour, expressed on plain integers.
    task automatic model_apply(input bit s, input bit p, input bit r,
                               input bit d, input bit n, input bit c);
        if (s) begin
            m_ph = P_ADDR; m_cnt = 0; m_idx = 0; m_a = 0; m_b = 0; m_f = 0;
        end else if (p || c) begin
            m_ph = P_IDLE; m_cnt = 0; m_idx = 0; m_a = 0; m_b = 0; m_f = 0;
        end else if (n && m_cnt == 8 && ((m_ph == P_ADDR && m_a == 1) || m_ph == P_DATA)) begin
            if (m_ph == P_ADDR) begin
                m_ph = P_DATA; m_a = 0; m_cnt = 0; m_idx = 0;
            end else begin
                m_b = 0; m_cnt = 0;
                if (m_f == 1) m_ph = P_WAIT;
                else m_idx = m_idx + 1;
            end
        end else if (r && (m_ph == P_ADDR || m_ph == P_DATA) && m_cnt < 8) begin
            m_sh  = (m_sh * 2 + int'(d)) % 256;
            m_cnt = m_cnt + 1;
            if (m_cnt == 8) begin
                if (m_ph == P_ADDR) begin
                    if (m_sh % 2 == 0 && (m_sh / 2 == OWN || (GC == 1 && m_sh / 2 == 0)))
                        m_a = 1;
                    else
                        m_ph = P_WAIT;
                end else begin
                    m_b = 1;
                    if (m_idx == FB - 1) m_f = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("addrok",  int'(addrok_out),  m_a);
        chk("byteok",  int'(byteok_out),  m_b);
        chk("frameok", int'(frameok_out), m_f);
        chk("lastbit", int'(lastbit_out),
            (m_cnt == 7 && (m_ph == P_ADDR || m_ph == P_DATA)) ? 1 : 0);
        chk("rxbyte",  int'(rxbyte_out),  m_sh);
        chk("byteidx", int'(byteidx_out), m_idx);
    endtask

    // Drive one cycle of inputs, advance the model, compare on the falling edge.
    task automatic step(input bit s, input bit p, input bit r,
                        input bit d, input bit n, input bit c);
        start_in = s; stop_in = p; scl_rise_in = r; sda_in = d;
        next_in = n; clr_in = c;
        @(posedge clk);
        model_apply(s, p, r, d, n, c);
        @(negedge clk);
        start_in = 1'b0; stop_in = 1'b0; scl_rise_in = 1'b0;
        next_in = 1'b0; clr_in = 1'b0;
        compare_all();
    endtask

    task automatic idle();           step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic rise(input bit d); step(1'b0, 1'b0, 1'b1, d,    1'b0, 1'b0); endtask
    task automatic start();          step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic stop();           step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic nxt();            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic clr();            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

    // Shift the top nbits of v, MSB first, with an idle cycle after each rise.
    task automatic send_bits(input logic [7:0] v, input int nbits);
        for (int i = 7; i >= 8 - nbits; i--) begin
            rise(v[i]);
            idle();
        end
    endtask

    logic [7:0] data_tbl [4] = '{8'hA5, 8'h00, 8'hFF, 8'h5A};

    initial begin
        model_reset();
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_addrok",  int'(addrok_out),  0);
        chk("rst_frameok", int'(frameok_out), 0);
        chk("rst_rxbyte",  int'(rxbyte_out),  0);
        chk("rst_byteidx", int'(byteidx_out), 0);
        rst_n = 1'b1;
        idle();

        // valid address 0111010 + W
        start();
        send_bits(8'h74, 7);
        chk("lit_lastbit7", int'(lastbit_out), 1);
        chk("lit_addr_pre", int'(addrok_out), 0);
        rise(1'b0);
        chk("lit_addrok", int'(addrok_out), 1);
        chk("lit_addr_rx", int'(rxbyte_out), 8'h74);
        rise(1'b1);                          // ACK slot: ignored
        chk("lit_ack_rx", int'(rxbyte_out), 8'h74);
        nxt();
        chk("lit_addr_clr", int'(addrok_out), 0);

        // four data bytes
        for (int k = 0; k < 4; k++) begin
            send_bits(data_tbl[k], 8);
            chk("lit_byteok", int'(byteok_out), 1);
            chk("lit_rxbyte", int'(rxbyte_out), int'(data_tbl[k]));
            chk("lit_byteidx", int'(byteidx_out), k);
            chk("lit_frameok", int'(frameok_out), (k == 3) ? 1 : 0);
            nxt();
        end
        chk("lit_frame_hold", int'(frameok_out), 1);
        chk("lit_byte_clr", int'(byteok_out), 0);
        rise(1'b1); rise(1'b0); rise(1'b1);  // ignored in WAIT_STOP
        chk("lit_wait_rx", int'(rxbyte_out), 8'h5A);
        stop();
        chk("lit_stop_frame", int'(frameok_out), 0);

        // wrong address 7'h3B + W
        start();
        send_bits(8'h76, 8);
        chk("lit_bad_addr", int'(addrok_out), 0);
        rise(1'b0); rise(1'b1); rise(1'b0); rise(1'b1);
        chk("lit_bad_rx", int'(rxbyte_out), 8'h76);
        nxt();
        stop();

        // STOP after 5 bits of data byte 1
        start();
        send_bits(8'h74, 8);
        nxt();
        send_bits(8'h3C, 8);
        nxt();
        send_bits(8'hC3, 5);
        stop();
        chk("lit_stop_addrok",  int'(addrok_out),  0);
        chk("lit_stop_byteok",  int'(byteok_out),  0);
        chk("lit_stop_byteidx", int'(byteidx_out), 0);
        chk("lit_stop_lastbit", int'(lastbit_out), 0);
        start();
        send_bits(8'h74, 8);
        chk("lit_readdr", int'(addrok_out), 1);

        // repeated START coincident with SCL rise mid-byte
        nxt();
        send_bits(8'h96, 3);                 // 0x74 << 3 | 3'b100 = 0xA4
        chk("lit_mid_rx", int'(rxbyte_out), 8'hA4);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit_rs_rx", int'(rxbyte_out), 8'hA4);
        chk("lit_rs_lastbit", int'(lastbit_out), 0);
        send_bits(8'h74, 7);
        chk("lit_rs_lastbit7", int'(lastbit_out), 1);
        rise(1'b0);
        chk("lit_rs_addrok", int'(addrok_out), 1);

        // next_in before the byte is complete is ignored; then clr aborts
        nxt();
        send_bits(8'hF0, 2);
        nxt();
        send_bits(8'h0F, 2);
        clr();
        chk("lit_clr_idx", int'(byteidx_out), 0);
        rise(1'b1);                          // IDLE ignores SCL

        // general call address
        start();
        send_bits(8'h00, 8);
        chk("lit_gencall", int'(addrok_out), GC);
        stop();

        // reset mid-frame
        start();
        send_bits(8'h74, 8);
        nxt();
        send_bits(8'hFF, 4);
        rst_n = 1'b0;
        #1;
        chk("lit_arst_rx",   int'(rxbyte_out),  0);
        chk("lit_arst_idx",  int'(byteidx_out), 0);
        chk("lit_arst_last", int'(lastbit_out), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        start();
        send_bits(8'h74, 8);
        chk("lit_post_rst", int'(addrok_out), 1);
        stop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
